// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, drives the instruction ROM address and
// latches the returned word into the IF/ID register for decode.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [25:0] jump_index,
  input  logic        jr,
  input  logic [31:0] jr_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        align_err,
  output logic [31:0] fetch_count
);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_plus4;
  logic [31:0] tgt_raw;
  logic        redir;
  if_id_t      ifid_q, ifid_d;
  logic        align_q, align_d;
  logic [31:0] cnt_q, cnt_d;

  assign pc_plus4 = pc_q + 32'd4;

  // Redirect priority: jr over jump over branch; the raw
  // target keeps its low bits so misalignment can be flagged.
  always_comb begin
    tgt_raw = pc_plus4;
    redir   = 1'b0;
    priority case (1'b1)
      jr: begin
        tgt_raw = jr_target;
        redir   = 1'b1;
      end
      jump: begin
        tgt_raw = {ifid_q.pc4[31:28], jump_index, 2'b00};
        redir   = 1'b1;
      end
      branch_taken: begin
        tgt_raw = branch_target;
        redir   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    pc_d    = pc_q;
    align_d = align_q;
    if (!stall) begin
      pc_d = {tgt_raw[31:2], 2'b00};
      if (redir && (tgt_raw[1:0] != 2'b00))
        align_d = 1'b1;
    end
  end

  // Flush wins over stall so a held slot can still be squashed.
  always_comb begin
    ifid_d = ifid_q;
    cnt_d  = cnt_q;
    if (flush) begin
      ifid_d = '0;
    end else if (!stall) begin
      ifid_d.instr = imem_instr;
      ifid_d.pc4   = pc_plus4;
      ifid_d.valid = 1'b1;
      cnt_d        = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= {RESET_PC[31:2], 2'b00};
      ifid_q  <= '0;
      align_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      ifid_q  <= ifid_d;
      align_q <= align_d;
      cnt_q   <= cnt_d;
    end
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign if_id_instr = ifid_q.instr;
  assign if_id_pc4   = ifid_q.pc4;
  assign if_id_valid = ifid_q.valid;
  assign align_err   = align_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with an IF/ID scoreboard
// and a second instance exercising PC wrap-around.
module tb_instruction_fetch;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        v;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, w_reset;
  logic        stall, flush, branch_taken, jump, jr;
  logic [31:0] branch_target, jr_target;
  logic [25:0] jump_index;
  logic [31:0] imem_addr, imem_instr, pc;
  logic [31:0] if_id_instr, if_id_pc4, fetch_count;
  logic        if_id_valid, align_err;

  logic [31:0] w_addr, w_instr, w_pc;
  logic [31:0] w_ifid_instr, w_ifid_pc4, w_cnt;
  logic        w_valid, w_align;

  int   checks = 0;
  int   errors = 0;
  exp_t q[$];
  exp_t hold_e;
  logic [31:0] cur_pc;
  logic [31:0] exp_cnt;

  function automatic logic [31:0] rom(input logic [31:0] a);
    if (a == 32'h8) return 32'h0C00_0004;
    return {~a[15:0], a[15:0]};
  endfunction

  assign imem_instr = rom(imem_addr);
  assign w_instr    = rom(w_addr);

  always #5 clk = ~clk;

  instruction_fetch #(.RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_index(jump_index),
    .jr(jr), .jr_target(jr_target),
    .imem_addr(imem_addr), .imem_instr(imem_instr), .pc(pc),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
    .if_id_valid(if_id_valid), .align_err(align_err),
    .fetch_count(fetch_count)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .reset(w_reset), .stall(1'b0), .flush(1'b0),
    .branch_taken(1'b0), .branch_target(32'h0),
    .jump(1'b0), .jump_index(26'h0),
    .jr(1'b0), .jr_target(32'h0),
    .imem_addr(w_addr), .imem_instr(w_instr), .pc(w_pc),
    .if_id_instr(w_ifid_instr), .if_id_pc4(w_ifid_pc4),
    .if_id_valid(w_valid), .align_err(w_align),
    .fetch_count(w_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic s, input logic f,
                      input logic b, input logic [31:0] bt,
                      input logic j, input logic [25:0] ji,
                      input logic r, input logic [31:0] rt,
                      input logic [31:0] npc);
    exp_t e, got;
    stall = s; flush = f;
    branch_taken = b; branch_target = bt;
    jump = j; jump_index = ji;
    jr = r; jr_target = rt;
    if (f) e = '0;
    else if (s) e = hold_e;
    else begin
      e.instr = rom(cur_pc);
      e.pc4   = cur_pc + 32'd4;
      e.v     = 1'b1;
      exp_cnt = exp_cnt + 32'd1;
    end
    q.push_back(e);
    hold_e = e;
    @(posedge clk);
    #1;
    chk("sb_nonempty", 32'(q.size()), 32'd1);
    if (q.size() != 0) begin
      got = q.pop_front();
      chk("if_id_instr", if_id_instr, got.instr);
      chk("if_id_pc4", if_id_pc4, got.pc4);
      chk("if_id_valid", 32'(if_id_valid), 32'(got.v));
    end
    chk("pc", pc, npc);
    chk("imem_addr", imem_addr, npc);
    chk("fetch_count", fetch_count, exp_cnt);
    cur_pc = npc;
  endtask

  task automatic seq(input logic [31:0] npc);
    step(0, 0, 0, 0, 0, 0, 0, 0, npc);
  endtask

  initial begin
    reset = 1'b0; w_reset = 1'b0;
    stall = 0; flush = 0; branch_taken = 0; jump = 0; jr = 0;
    branch_target = 0; jr_target = 0; jump_index = 0;
    cur_pc = 0; exp_cnt = 0; hold_e = '0;
    #12;
    chk("rst_pc", pc, 32'h0);
    chk("rst_instr", if_id_instr, 32'h0);
    chk("rst_pc4", if_id_pc4, 32'h0);
    chk("rst_valid", 32'(if_id_valid), 32'd0);
    chk("rst_align", 32'(align_err), 32'd0);
    chk("rst_count", fetch_count, 32'h0);
    reset = 1'b1;

    seq(32'h4);
    seq(32'h8);
    seq(32'hC);
    chk("seq_instr", if_id_instr, 32'h0C00_0004);
    chk("seq_pc4", if_id_pc4, 32'hC);
    chk("seq_count", fetch_count, 32'd3);

    step(0, 0, 1, 32'h40, 1, 26'd4, 0, 0, 32'h10);
    seq(32'h14);
    seq(32'h18);
    seq(32'h1C);
    seq(32'h20);

    step(1, 0, 0, 0, 0, 0, 0, 0, 32'h20);
    step(1, 0, 0, 0, 0, 0, 0, 0, 32'h20);
    chk("stall_count", fetch_count, 32'd8);
    seq(32'h24);

    step(0, 1, 1, 32'h2C, 0, 0, 0, 0, 32'h2C);
    chk("br_flush_count", fetch_count, 32'd9);
    chk("align_clean", 32'(align_err), 32'd0);
    seq(32'h30);

    step(0, 0, 0, 0, 0, 0, 1, 32'h29, 32'h28);
    chk("align_set", 32'(align_err), 32'd1);
    for (int i = 0; i < 5; i++) begin
      seq(32'h2C + 32'(4 * i));
      chk("align_sticky", 32'(align_err), 32'd1);
    end

    step(1, 1, 0, 0, 0, 0, 0, 0, 32'h3C);
    step(1, 0, 0, 0, 0, 0, 1, 32'h100, 32'h3C);
    step(0, 0, 0, 0, 0, 0, 1, 32'h100, 32'h100);

    w_reset = 1'b1;
    seq(32'h104);
    chk("wrap_pc1", w_pc, 32'hFFFF_FFFC);
    chk("wrap_pc4_1", w_ifid_pc4, 32'hFFFF_FFFC);
    seq(32'h108);
    chk("wrap_pc2", w_pc, 32'h0);
    chk("wrap_pc4_2", w_ifid_pc4, 32'h0);
    chk("wrap_instr", w_ifid_instr, rom(32'hFFFF_FFFC));
    chk("wrap_count", w_cnt, 32'd2);

    jr = 1'b1; jr_target = 32'h200;
    #3;
    reset = 1'b0; w_reset = 1'b0;
    #1;
    chk("arst_pc", pc, 32'h0);
    chk("arst_instr", if_id_instr, 32'h0);
    chk("arst_pc4", if_id_pc4, 32'h0);
    chk("arst_valid", 32'(if_id_valid), 32'd0);
    chk("arst_align", 32'(align_err), 32'd0);
    chk("arst_count", fetch_count, 32'h0);
    chk("arst_w_pc", w_pc, 32'hFFFF_FFF8);
    chk("arst_w_count", w_cnt, 32'h0);
    @(posedge clk);
    #1;
    chk("arst_hold_pc", pc, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
